// File: rtl/mem_wb_elastic_reg_if.sv
// Handshake bundle between the MEM stage, the MEM/WB elastic register and WB.
// The master modport belongs to whoever drives the register's inputs.
interface mem_wb_elastic_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 2
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_value;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_mem_value;
  logic [DEST_W-1:0] out_dest;
  logic [1:0]        occupancy;

  modport master (
    output stall, flush, in_valid, in_ctrl, in_alu_result, in_mem_value, in_dest, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu_result, out_mem_value, out_dest, occupancy
  );

  modport slave (
    input  stall, flush, in_valid, in_ctrl, in_alu_result, in_mem_value, in_dest, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu_result, out_mem_value, out_dest, occupancy
  );
endinterface

// File: rtl/mem_wb_elastic_reg.sv
// MEM->WB stage register with valid/ready flow control, stall, flush and an
// optional 2-entry skid buffer that keeps in_ready off the combinational path.
module mem_wb_elastic_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input logic                  clk,
  input logic                  rst,
  mem_wb_elastic_reg_if.slave  bus
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DEST_W-1:0] dest;
  } entry_t;

  entry_t in_e, main_q, main_d;
  logic   in_fire, out_fire;

  assign in_e     = '{ctrl: bus.in_ctrl, alu: bus.in_alu_result,
                      mem: bus.in_mem_value, dest: bus.in_dest};
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready & ~bus.stall;

  // Head entry is always in main_q; it is zeroed whenever it is not valid.
  assign bus.out_ctrl       = main_q.ctrl;
  assign bus.out_alu_result = main_q.alu;
  assign bus.out_mem_value  = main_q.mem;
  assign bus.out_dest       = main_q.dest;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) main_q <= '0;
    else      main_q <= main_d;
  end

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
      state_t state_q, state_d;
      entry_t skid_q, skid_d;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= EMPTY;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          skid_q  <= skid_d;
        end
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          case (state_q)
            EMPTY: if (in_fire) begin
              state_d = ONE;
              main_d  = in_e;
            end
            ONE: begin
              if (in_fire && out_fire) begin
                main_d = in_e;
              end else if (in_fire) begin
                state_d = TWO;
                skid_d  = in_e;
              end else if (out_fire) begin
                state_d = EMPTY;
                main_d  = '0;
              end
            end
            TWO: if (out_fire) begin
              state_d = ONE;
              main_d  = skid_q;
              skid_d  = '0;
            end
            default: begin
              state_d = EMPTY;
              main_d  = '0;
              skid_d  = '0;
            end
          endcase
        end
      end

      // Ready comes from the state flop only, never from out_ready.
      assign bus.in_ready  = (state_q != TWO) & ~bus.stall;
      assign bus.out_valid = (state_q != EMPTY);
      assign bus.occupancy = state_q;
    end else begin : g_single
      logic v_q, v_d;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) v_q <= 1'b0;
        else      v_q <= v_d;
      end

      always_comb begin
        v_d    = v_q;
        main_d = main_q;
        if (bus.flush) begin
          v_d    = 1'b0;
          main_d = '0;
        end else if (in_fire) begin
          v_d    = 1'b1;
          main_d = in_e;
        end else if (out_fire) begin
          v_d    = 1'b0;
          main_d = '0;
        end
      end

      assign bus.in_ready  = (~v_q | bus.out_ready) & ~bus.stall;
      assign bus.out_valid = v_q;
      assign bus.occupancy = {1'b0, v_q};
    end
  endgenerate

endmodule
